// File: rtl/cnf_stream_loader.sv
// Purpose: turns a signed-literal DIMACS stream into per-clause pos/neg masks for the SAT core.
// Latency: a clause commits one cycle after its terminator; ended/error rise one cycle after the final or offending beat.
// Backpressure: none inside a load (lit_ready stays high every LOAD cycle); beats outside LOAD are ignored.
module cnf_stream_loader #(
  parameter int NUM_VARS    = 8,
  parameter int MAX_CLAUSES = 16,
  parameter int LIT_W       = $clog2(NUM_VARS + 1) + 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 load,
  input  logic                                 lit_valid,
  input  logic signed [LIT_W-1:0]              lit_in,
  input  logic                                 lit_last,
  output logic                                 lit_ready,
  output logic [MAX_CLAUSES*NUM_VARS-1:0]      pos_mask,
  output logic [MAX_CLAUSES*NUM_VARS-1:0]      neg_mask,
  output logic [MAX_CLAUSES-1:0]               clause_valid,
  output logic [$clog2(MAX_CLAUSES+1)-1:0]     num_clauses,
  output logic                                 has_empty,
  output logic                                 ended,
  output logic                                 error,
  output logic [1:0]                           err_code
);

  localparam int CNT_W = $clog2(MAX_CLAUSES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  // Most negative literal has no positive counterpart, so it is always illegal.
  localparam logic [LIT_W-1:0] LIT_MIN  = {1'b1, {(LIT_W-1){1'b0}}};
  localparam logic [LIT_W-1:0] MAG_MAX  = LIT_W'(NUM_VARS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_CLAUSES);

  logic [1:0]          state;
  logic [NUM_VARS-1:0] wpos;
  logic [NUM_VARS-1:0] wneg;
  logic                lit_seen;   // working clause holds at least one literal
  logic                beat_seen;  // any beat accepted since the last load

  logic                beat;
  logic                is_zero;
  logic                range_err;
  logic [LIT_W-1:0]    mag;
  logic [NUM_VARS-1:0] sel;
  logic [NUM_VARS-1:0] wpos_n;
  logic [NUM_VARS-1:0] wneg_n;
  logic                seen_n;
  logic                commit;
  logic                taut;
  logic                set_empty;
  logic                store_en;
  logic                ovf;

  // Decode the current beat: legality, merged working clause and commit outcome.
  always_comb begin
    beat      = (state == S_LOAD) && lit_valid && !load;
    is_zero   = (lit_in == '0);
    mag       = lit_in[LIT_W-1] ? ((~lit_in) + LIT_W'(1)) : lit_in;
    range_err = (lit_in == LIT_MIN) || (mag > MAG_MAX);
    for (int v = 0; v < NUM_VARS; v++) begin
      sel[v] = (mag == LIT_W'(v + 1));
    end
    wpos_n = wpos;
    wneg_n = wneg;
    if (!is_zero) begin
      if (lit_in[LIT_W-1]) wneg_n = wneg | sel;
      else                 wpos_n = wpos | sel;
    end
    seen_n = lit_seen | !is_zero;
    // A final nonzero literal closes its clause implicitly in the same cycle.
    commit = beat && !range_err && (is_zero || lit_last);
    taut   = |(wpos_n & wneg_n);
    // A trailing terminator after other beats only closes the stream; it is not an empty clause.
    set_empty = commit && !seen_n && !(lit_last && beat_seen);
    store_en  = commit && seen_n && !taut && (num_clauses != CNT_FULL);
    ovf       = commit && seen_n && !taut && (num_clauses == CNT_FULL);
  end

  // Control FSM, working clause and clause storage; load always wins over a same-cycle beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      lit_ready    <= 1'b0;
      ended        <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      has_empty    <= 1'b0;
      pos_mask     <= '0;
      neg_mask     <= '0;
      clause_valid <= '0;
      num_clauses  <= '0;
      wpos         <= '0;
      wneg         <= '0;
      lit_seen     <= 1'b0;
      beat_seen    <= 1'b0;
    end else if (load) begin
      state        <= S_LOAD;
      lit_ready    <= 1'b1;
      ended        <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      has_empty    <= 1'b0;
      pos_mask     <= '0;
      neg_mask     <= '0;
      clause_valid <= '0;
      num_clauses  <= '0;
      wpos         <= '0;
      wneg         <= '0;
      lit_seen     <= 1'b0;
      beat_seen    <= 1'b0;
    end else if (beat) begin
      beat_seen <= 1'b1;
      if (range_err || ovf) begin
        state     <= S_ERROR;
        lit_ready <= 1'b0;
        error     <= 1'b1;
        err_code  <= range_err ? 2'd1 : 2'd2;
      end else begin
        if (commit) begin
          wpos     <= '0;
          wneg     <= '0;
          lit_seen <= 1'b0;
        end else begin
          wpos     <= wpos_n;
          wneg     <= wneg_n;
          lit_seen <= seen_n;
        end
        if (set_empty) has_empty <= 1'b1;
        if (store_en) begin
          for (int k = 0; k < MAX_CLAUSES; k++) begin
            if (num_clauses == CNT_W'(k)) begin
              pos_mask[k*NUM_VARS +: NUM_VARS] <= wpos_n;
              neg_mask[k*NUM_VARS +: NUM_VARS] <= wneg_n;
              clause_valid[k]                  <= 1'b1;
            end
          end
          num_clauses <= num_clauses + CNT_W'(1);
        end
        if (lit_last) begin
          state     <= S_DONE;
          lit_ready <= 1'b0;
          ended     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnf_stream_loader.sv
// Purpose: self-checking bench for cnf_stream_loader; expected formula images are queued per stream.
// Latency: checks commit and status latency of one cycle after the relevant beat.
// Backpressure: beats are driven every cycle while loading; beats outside LOAD must be ignored.
module tb_cnf_stream_loader;

  localparam int NV = 8;
  localparam int MC = 16;
  localparam int LW = 5;
  localparam int CW = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 load;
  logic                 lit_valid;
  logic signed [LW-1:0] lit_in;
  logic                 lit_last;
  logic                 lit_ready;
  logic [MC*NV-1:0]     pos_mask;
  logic [MC*NV-1:0]     neg_mask;
  logic [MC-1:0]        clause_valid;
  logic [CW-1:0]        num_clauses;
  logic                 has_empty;
  logic                 ended;
  logic                 error;
  logic [1:0]           err_code;

  cnf_stream_loader #(.NUM_VARS(NV), .MAX_CLAUSES(MC)) dut (
    .clock        (clock),
    .reset        (reset),
    .load         (load),
    .lit_valid    (lit_valid),
    .lit_in       (lit_in),
    .lit_last     (lit_last),
    .lit_ready    (lit_ready),
    .pos_mask     (pos_mask),
    .neg_mask     (neg_mask),
    .clause_valid (clause_valid),
    .num_clauses  (num_clauses),
    .has_empty    (has_empty),
    .ended        (ended),
    .error        (error),
    .err_code     (err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             done_ok;
    logic [1:0]       code;
    logic             full;
    logic             he;
    logic [CW-1:0]    num;
    logic [MC*NV-1:0] pos;
    logic [MC*NV-1:0] neg;
    logic [MC-1:0]    cv;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [MC*NV-1:0] got, input logic [MC*NV-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk_done(input int num, input logic he, input logic [MC*NV-1:0] p,
                                   input logic [MC*NV-1:0] n, input logic [MC-1:0] cv);
    exp_t e;
    e.done_ok = 1'b1; e.code = 2'd0; e.full = 1'b1; e.he = he;
    e.num = CW'(num); e.pos = p; e.neg = n; e.cv = cv;
    return e;
  endfunction

  function automatic exp_t mk_err(input logic [1:0] code);
    exp_t e;
    e.done_ok = 1'b0; e.code = code; e.full = 1'b0; e.he = 1'b0;
    e.num = '0; e.pos = '0; e.neg = '0; e.cv = '0;
    return e;
  endfunction

  task automatic beat(input int v, input logic last);
    @(negedge clock);
    lit_valid = 1'b1;
    lit_in    = LW'(v);
    lit_last  = last;
  endtask

  task automatic do_load();
    @(negedge clock);
    lit_valid = 1'b0;
    lit_last  = 1'b0;
    load      = 1'b1;
    @(negedge clock);
    load = 1'b0;
    check_val("ready_after_load", lit_ready, 1);
  endtask

  // Close the stream: the status must be visible one cycle after the last driven beat.
  task automatic finish_stream(input string name);
    exp_t e;
    @(negedge clock);
    lit_valid = 1'b0;
    lit_last  = 1'b0;
    check_val({name, "_latency"}, ended | error, 1);
    for (int i = 0; i < 8 && !(ended || error); i++) @(negedge clock);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_scoreboard: got output with no queued expectation", name);
      return;
    end
    e = exp_q.pop_front();
    check_val({name, "_ended"}, ended, e.done_ok);
    check_val({name, "_error"}, error, !e.done_ok);
    check_val({name, "_code"}, err_code, e.code);
    check_val({name, "_ready"}, lit_ready, 0);
    if (e.full) begin
      check_val({name, "_num"}, num_clauses, e.num);
      check_val({name, "_empty"}, has_empty, e.he);
      check_val({name, "_pos"}, pos_mask, e.pos);
      check_val({name, "_neg"}, neg_mask, e.neg);
      check_val({name, "_cvalid"}, clause_valid, e.cv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [MC*NV-1:0] p16;
    logic [MC*NV-1:0] n16;

    reset = 1'b1; load = 1'b0; lit_valid = 1'b0; lit_in = '0; lit_last = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_ready", lit_ready, 0);
    check_val("rst_ended", ended, 0);
    check_val("rst_error", error, 0);
    check_val("rst_code", err_code, 0);
    check_val("rst_num", num_clauses, 0);
    check_val("rst_pos", pos_mask | neg_mask, 0);
    check_val("rst_empty", has_empty, 0);
    reset = 1'b0;

    // Beats while idle are ignored.
    beat(3, 1);
    @(negedge clock);
    lit_valid = 1'b0;
    check_val("idle_ignore_num", num_clauses, 0);
    check_val("idle_ignore_ended", ended, 0);

    // Three-clause formula with a commit-latency probe.
    do_load();
    exp_q.push_back(mk_done(3, 0, 128'h0601, 128'h010004, 16'h0007));
    beat(1, 0); beat(-3, 0); beat(0, 0); beat(2, 0);
    check_val("commit_latency_num", num_clauses, 1);
    check_val("commit_latency_pos0", pos_mask[7:0], 8'h01);
    beat(3, 0); beat(0, 0); beat(-1, 1);
    finish_stream("s1");

    // Duplicate literals merge.
    do_load();
    exp_q.push_back(mk_done(1, 0, 128'h08, 128'h02, 16'h0001));
    beat(4, 0); beat(4, 0); beat(-2, 0); beat(0, 1);
    finish_stream("dup");

    // Tautology dropped.
    do_load();
    exp_q.push_back(mk_done(0, 0, 0, 0, 0));
    beat(2, 0); beat(-2, 0); beat(5, 0); beat(0, 1);
    finish_stream("taut");

    // Leading empty clause.
    do_load();
    exp_q.push_back(mk_done(1, 1, 128'h01, 0, 16'h0001));
    beat(0, 0); beat(1, 0); beat(0, 1);
    finish_stream("empty");

    // Trailing terminator after a complete clause is not an empty clause.
    do_load();
    exp_q.push_back(mk_done(1, 0, 128'h10, 0, 16'h0001));
    beat(5, 0); beat(0, 0); beat(0, 1);
    finish_stream("trail");

    // A lone final terminator is an empty formula clause.
    do_load();
    exp_q.push_back(mk_done(0, 1, 0, 0, 0));
    beat(0, 1);
    finish_stream("lone0");

    // Out-of-range literal, stickiness, then recovery.
    do_load();
    exp_q.push_back(mk_err(2'd1));
    beat(1, 0); beat(0, 0); beat(2, 0); beat(9, 0);
    finish_stream("range");
    beat(1, 1);
    @(negedge clock);
    lit_valid = 1'b0;
    check_val("err_sticky", error, 1);
    do_load();
    check_val("reload_error", error, 0);
    check_val("reload_num", num_clauses, 0);
    check_val("reload_pos", pos_mask | neg_mask, 0);
    exp_q.push_back(mk_done(1, 0, 128'h04, 0, 16'h0001));
    beat(3, 0); beat(0, 1);
    finish_stream("recover");

    // Most negative literal is illegal.
    do_load();
    exp_q.push_back(mk_err(2'd1));
    beat(-16, 0);
    finish_stream("minlit");

    // Load during LOAD aborts; the same-cycle beat is discarded.
    do_load();
    beat(7, 0);
    @(negedge clock);
    load = 1'b1; lit_valid = 1'b1; lit_in = LW'(5); lit_last = 1'b1;
    @(negedge clock);
    load = 1'b0; lit_valid = 1'b0; lit_last = 1'b0;
    check_val("abort_ready", lit_ready, 1);
    check_val("abort_ended", ended, 0);
    exp_q.push_back(mk_done(1, 0, 128'h20, 0, 16'h0001));
    beat(6, 0); beat(0, 1);
    finish_stream("abort");

    // Capacity overflow on the 17th real clause.
    do_load();
    exp_q.push_back(mk_err(2'd2));
    for (int i = 0; i < 16; i++) begin
      beat((i < 8) ? (i + 1) : -(i - 7), 0);
      beat(0, 0);
    end
    beat(1, 0); beat(2, 0); beat(0, 0);
    finish_stream("ovf");

    // Full store followed by a tautology never overflows.
    p16 = '0;
    n16 = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) p16[i*NV + i] = 1'b1;
      else       n16[i*NV + i - 8] = 1'b1;
    end
    do_load();
    exp_q.push_back(mk_done(16, 0, p16, n16, 16'hFFFF));
    for (int i = 0; i < 16; i++) begin
      beat((i < 8) ? (i + 1) : -(i - 7), 0);
      beat(0, 0);
    end
    beat(1, 0); beat(-1, 0); beat(0, 1);
    finish_stream("full_taut");

    // Asynchronous reset mid-load.
    do_load();
    beat(1, 0); beat(0, 0); beat(2, 0); beat(0, 0); beat(3, 0); beat(0, 0);
    @(negedge clock);
    lit_valid = 1'b0;
    check_val("pre_reset_num", num_clauses, 3);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_num", num_clauses, 0);
    check_val("async_rst_ready", lit_ready, 0);
    check_val("async_rst_pos", pos_mask | neg_mask, 0);
    check_val("async_rst_cvalid", clause_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    beat(4, 1);
    @(negedge clock);
    lit_valid = 1'b0; lit_last = 1'b0;
    check_val("post_rst_num", num_clauses, 0);
    check_val("post_rst_ended", ended, 0);
    check_val("post_rst_pos", pos_mask, 0);

    check_val("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnf_stream_loader.md
# cnf_stream_loader

Front-end stage of the hardware SAT solver: accepts a DIMACS-style stream of signed literals, one per cycle, and builds the clause-mask formula image that the solver top consumes before kernelization. It validates the stream, merges duplicate literals, drops tautological clauses, flags empty clauses and reports a registered completion/error status.

## Interface
Parameters:
- NUM_VARS, 8, number of variables; legal literal magnitudes are 1..NUM_VARS
- MAX_CLAUSES, 16, clause storage capacity
- LIT_W, $clog2(NUM_VARS+1)+1, signed literal width (two's complement)

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- load  in  1  start/restart pulse; sampled every cycle
- lit_valid  in  1  literal beat valid
- lit_in  in  LIT_W  signed literal; 0 = clause terminator
- lit_last  in  1  final beat of the formula
- lit_ready  out  1  beat accepted when lit_valid && lit_ready
- pos_mask  out  MAX_CLAUSES*NUM_VARS  clause k bit v-1 = literal +v present
- neg_mask  out  MAX_CLAUSES*NUM_VARS  clause k bit v-1 = literal -v present
- clause_valid  out  MAX_CLAUSES  clause k committed
- num_clauses  out  $clog2(MAX_CLAUSES+1)  committed clause count
- has_empty  out  1  an empty clause was read (formula trivially UNSAT)
- ended  out  1  level; load complete, outputs stable
- error  out  1  level; stream rejected
- err_code  out  2  0 none, 1 range, 2 overflow

## Operation
- States: IDLE, LOAD, DONE, ERROR. All outputs registered.
- IDLE: lit_ready=0. load=1 -> clear all arrays, counters, flags, working clause -> LOAD.
- LOAD: lit_ready=1. Per accepted beat:
  - lit_in nonzero, |lit_in| in 1..NUM_VARS: OR bit into working pos/neg mask; set lit_seen. Duplicates idempotent.
  - |lit_in| = 0 is terminator; |lit_in| > NUM_VARS or lit_in = -2^(LIT_W-1): err_code=1 -> ERROR.
  - Terminator commit: if lit_seen=0 -> has_empty=1, nothing stored. Else if (pos & neg) != 0 -> tautology, dropped silently. Else if num_clauses = MAX_CLAUSES -> err_code=2 -> ERROR. Else store at index num_clauses, set clause_valid bit, num_clauses+1. Working clause and lit_seen cleared.
  - lit_last on nonzero literal: literal merged then implicit terminator commit in same cycle.
  - lit_last on terminator with no literals in clause and at least one prior beat: no has_empty (trailing 0 only). A stream consisting solely of one terminator beat with lit_last sets has_empty.
  - After lit_last beat without error -> DONE.
- DONE: ended=1, lit_ready=0; outputs held. load=1 -> clear and LOAD.
- ERROR: error=1, ended=0, lit_ready=0; arrays hold partial contents (don't-care to consumer). Sticky until load or reset.
- load=1 while in LOAD: abort, clear, restart LOAD; a beat in that same cycle is discarded.

## Timing
- Reset: state IDLE; lit_ready, ended, error, has_empty=0; err_code=0; all masks, clause_valid, num_clauses=0.
- Throughput: one literal per cycle, no bubbles, including back-to-back terminators.
- lit_ready rises the cycle after load; beats with lit_valid=1 while lit_ready=0 ignored.
- Commit latency: clause visible on pos/neg_mask, clause_valid, num_clauses the cycle after its terminator beat.
- ended/error assert the cycle after the lit_last or offending beat; lit_ready deasserts the same cycle.
- Overflow check evaluated only on commit of a non-tautological, non-empty clause; tautologies and empty clauses never overflow.
- Reset mid-load: immediate return to reset values; no partial state survives.

## Test plan
- NUM_VARS=8: load; stream 1,-3,0,2,3,0,-1 with last -> ended after 1 cycle, num_clauses=3, clause0 pos=0x01 neg=0x04, clause1 pos=0x06, clause2 neg=0x01.
- Stream 4,4,-2,0 last -> single clause pos=0x08 neg=0x02 (duplicate merged); 2,-2,5,0 last -> clause dropped, num_clauses=0, ended=1.
- Stream 0,1,0 last -> has_empty=1, num_clauses=1, clause0 pos=0x01.
- Literal 9 mid-stream -> error=1, err_code=1, lit_ready=0 next cycle; load -> state cleared, clean load succeeds.
- MAX_CLAUSES=16: 17 distinct unit clauses -> 16 committed, 17th terminator -> err_code=2; with 16 plus one tautology -> ended, num_clauses=16.
- Assert reset during LOAD after 3 clauses -> all outputs zero, IDLE; lit_valid pulses ignored until load.
